// File: rtl/edge_event_pkg.sv
// rtl/edge_event_pkg.sv - event record layout shared by the logger blocks
package edge_event_pkg;

  localparam int B_CHG_BIT = 0;
  localparam int A_CHG_BIT = 1;
  localparam int B_VAL_BIT = 2;
  localparam int A_VAL_BIT = 3;
  localparam int TS_LSB    = 4;

  function automatic int rec_width(input int ts_w);
    return ts_w + TS_LSB;
  endfunction

endpackage

// File: rtl/sync_fifo_vr.sv
// rtl/sync_fifo_vr.sv - synchronous FIFO with valid/ready read side and occupancy count
module sync_fifo_vr #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 12
) (
  input  logic                     clock,
  input  logic                     reset_n,
  input  logic                     i_wr_valid,
  input  logic [WIDTH-1:0]         i_wr_data,
  output logic                     o_rd_valid,
  input  logic                     i_rd_ready,
  output logic [WIDTH-1:0]         o_rd_data,
  output logic [$clog2(DEPTH):0]   o_count,
  output logic                     o_full,
  output logic                     o_empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CW    = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_wr_ptr;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [CW-1:0]    r_count;
  logic             w_pop;
  logic             w_push;

  assign o_empty    = (r_count == '0);
  assign o_full     = (r_count == CW'(DEPTH));
  assign w_pop      = !o_empty && i_rd_ready;
  // A pop on the same edge frees the slot, so a write into a full FIFO is still taken.
  assign w_push     = i_wr_valid && (!o_full || w_pop);
  assign o_rd_valid = !o_empty;
  assign o_rd_data  = o_empty ? '0 : r_mem[r_rd_ptr];
  assign o_count    = r_count;

  always_ff @(posedge clock) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_wr_data;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

endmodule

// File: rtl/edge_event_logger.sv
// rtl/edge_event_logger.sv - time-stamped change logger for the a/b swap-register outputs
module edge_event_logger
  import edge_event_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TS_W  = 8,
  parameter int CNT_W = 8
) (
  input  logic                        clock,
  input  logic                        reset_n,
  input  logic                        a_in,
  input  logic                        b_in,
  input  logic                        enable,
  input  logic                        clear,
  output logic                        evt_valid,
  input  logic                        evt_ready,
  output logic [rec_width(TS_W)-1:0]  evt_data,
  output logic [CNT_W-1:0]            a_toggles,
  output logic [CNT_W-1:0]            b_toggles,
  output logic [$clog2(DEPTH):0]      fifo_count,
  output logic                        overflow
);

  localparam int REC_W = rec_width(TS_W);

  logic [TS_W-1:0]  r_ts;
  logic             r_a_last;
  logic             r_b_last;
  logic             r_primed;
  logic [CNT_W-1:0] r_a_tog;
  logic [CNT_W-1:0] r_b_tog;
  logic             r_overflow;

  logic             w_sample;
  logic             w_a_chg;
  logic             w_b_chg;
  logic             w_push;
  logic             w_pop;
  logic             w_drop;
  logic             w_fifo_full;
  logic             w_fifo_empty;
  logic [REC_W-1:0] w_record;

  // Change detection only once a reference sample exists.
  assign w_sample = enable && r_primed;
  assign w_a_chg  = w_sample && (a_in ^ r_a_last);
  assign w_b_chg  = w_sample && (b_in ^ r_b_last);
  assign w_push   = w_a_chg || w_b_chg;
  assign w_pop    = !w_fifo_empty && evt_ready;
  assign w_drop   = w_push && w_fifo_full && !w_pop;

  always_comb begin
    w_record                    = '0;
    w_record[REC_W-1:TS_LSB]    = r_ts;
    w_record[A_VAL_BIT]         = a_in;
    w_record[B_VAL_BIT]         = b_in;
    w_record[A_CHG_BIT]         = w_a_chg;
    w_record[B_CHG_BIT]         = w_b_chg;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_ts     <= '0;
      r_a_last <= 1'b0;
      r_b_last <= 1'b0;
      r_primed <= 1'b0;
    end else begin
      r_ts <= r_ts + TS_W'(1);
      if (enable) begin
        r_a_last <= a_in;
        r_b_last <= b_in;
        r_primed <= 1'b1;
      end
    end
  end

  // Clear wins over a same-cycle increment or drop.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      r_a_tog    <= '0;
      r_b_tog    <= '0;
      r_overflow <= 1'b0;
    end else if (clear) begin
      r_a_tog    <= '0;
      r_b_tog    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_a_chg && (r_a_tog != {CNT_W{1'b1}})) begin
        r_a_tog <= r_a_tog + CNT_W'(1);
      end
      if (w_b_chg && (r_b_tog != {CNT_W{1'b1}})) begin
        r_b_tog <= r_b_tog + CNT_W'(1);
      end
      if (w_drop) begin
        r_overflow <= 1'b1;
      end
    end
  end

  sync_fifo_vr #(
    .DEPTH (DEPTH),
    .WIDTH (REC_W)
  ) u_fifo (
    .clock      (clock),
    .reset_n    (reset_n),
    .i_wr_valid (w_push),
    .i_wr_data  (w_record),
    .o_rd_valid (evt_valid),
    .i_rd_ready (evt_ready),
    .o_rd_data  (evt_data),
    .o_count    (fifo_count),
    .o_full     (w_fifo_full),
    .o_empty    (w_fifo_empty)
  );

  assign a_toggles = r_a_tog;
  assign b_toggles = r_b_tog;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_edge_event_logger.sv
// tb/tb_edge_event_logger.sv - scoreboard bench for edge_event_logger
module tb_edge_event_logger;

  localparam int DEPTH   = 4;
  localparam int TS_W    = 8;
  localparam int CNT_W   = 4;
  localparam int REC_W   = TS_W + 4;
  localparam int CNT_MAX = (1 << CNT_W) - 1;

  logic                   clock = 1'b0;
  logic                   reset_n = 1'b1;
  logic                   a_in = 1'b0;
  logic                   b_in = 1'b0;
  logic                   enable = 1'b0;
  logic                   clear = 1'b0;
  logic                   evt_ready = 1'b0;
  logic                   evt_valid;
  logic [REC_W-1:0]       evt_data;
  logic [CNT_W-1:0]       a_toggles;
  logic [CNT_W-1:0]       b_toggles;
  logic [$clog2(DEPTH):0] fifo_count;
  logic                   overflow;

  int n_tests = 0;
  int n_fail  = 0;

  int m_ts;
  bit m_a, m_b, m_primed, m_ovf;
  int m_at, m_bt;
  int m_fifo[$];
  int sb_q[$];

  always #5 clock = ~clock;

  edge_event_logger #(
    .DEPTH (DEPTH),
    .TS_W  (TS_W),
    .CNT_W (CNT_W)
  ) dut (
    .clock      (clock),
    .reset_n    (reset_n),
    .a_in       (a_in),
    .b_in       (b_in),
    .enable     (enable),
    .clear      (clear),
    .evt_valid  (evt_valid),
    .evt_ready  (evt_ready),
    .evt_data   (evt_data),
    .a_toggles  (a_toggles),
    .b_toggles  (b_toggles),
    .fifo_count (fifo_count),
    .overflow   (overflow)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_ts = 0; m_a = 0; m_b = 0; m_primed = 0; m_ovf = 0;
    m_at = 0; m_bt = 0;
    m_fifo.delete();
    sb_q.delete();
  endtask

  task automatic check_state();
    check("fifo_count", fifo_count, m_fifo.size());
    check("evt_valid", evt_valid, m_fifo.size() != 0);
    check("a_toggles", a_toggles, m_at);
    check("b_toggles", b_toggles, m_bt);
    check("overflow", overflow, m_ovf);
  endtask

  // One clock of stimulus: the model applies the same edge, then state is compared.
  task automatic step(input bit a, input bit b, input bit en, input bit clr, input bit rdy);
    bit pop, ac, bc;
    int rec;
    a_in = a; b_in = b; enable = en; clear = clr; evt_ready = rdy;
    pop = (m_fifo.size() != 0) && rdy;
    ac = 0; bc = 0;
    if (en) begin
      if (m_primed) begin
        ac = (a != m_a);
        bc = (b != m_b);
      end
      m_primed = 1; m_a = a; m_b = b;
    end
    if (pop) void'(m_fifo.pop_front());
    if (ac || bc) begin
      rec = m_ts * 16 + a * 8 + b * 4 + ac * 2 + bc;
      if (m_fifo.size() < DEPTH) begin
        m_fifo.push_back(rec);
        sb_q.push_back(rec);
      end else begin
        m_ovf = 1;
      end
      if (ac) m_at = (m_at < CNT_MAX) ? m_at + 1 : CNT_MAX;
      if (bc) m_bt = (m_bt < CNT_MAX) ? m_bt + 1 : CNT_MAX;
    end
    if (clr) begin
      m_at = 0; m_bt = 0; m_ovf = 0;
    end
    m_ts = (m_ts + 1) % (1 << TS_W);
    @(posedge clock); #1;
    check_state();
  endtask

  always @(negedge clock) begin
    if (reset_n && evt_valid) begin
      if (sb_q.size() == 0) begin
        check("evt_unexpected", evt_data, 32'hFFFF_FFFF);
      end else begin
        check("evt_data", evt_data, sb_q[0]);
        if (evt_ready) void'(sb_q.pop_front());
      end
    end
  end

  initial begin
    model_reset();
    #2 reset_n = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    check("rst_evt_valid", evt_valid, 0);
    check("rst_evt_data", evt_data, 0);
    check("rst_fifo_count", fifo_count, 0);
    reset_n = 1'b1;

    // Prime, then a single change at ts=5
    step(1, 0, 1, 0, 0);
    check("prime_evt_data", evt_data, 0);
    repeat (4) step(1, 0, 1, 0, 0);
    step(0, 0, 1, 0, 0);
    check("single_rec", evt_data, 32'h052);
    check("single_a_tog", a_toggles, 1);
    repeat (2) step(0, 0, 1, 0, 1);

    // Swap pattern
    step(1, 0, 1, 1, 1);
    for (int i = 0; i < 10; i++) step(!m_a, !m_b, 1, 0, 1);
    check("swap_a_tog", a_toggles, 10);
    check("swap_b_tog", b_toggles, 10);
    repeat (3) step(m_a, m_b, 1, 0, 1);

    // Overflow, then full push with same-cycle pop
    step(m_a, m_b, 1, 1, 1);
    for (int i = 0; i < 6; i++) step(!m_a, m_b, 1, 0, 0);
    check("ovf_count", fifo_count, DEPTH);
    check("ovf_flag", overflow, 1);
    check("ovf_a_tog", a_toggles, 6);
    repeat (2) step(m_a, m_b, 1, 0, 0);
    step(m_a, m_b, 1, 1, 0);
    step(!m_a, m_b, 1, 0, 1);
    check("fullpp_count", fifo_count, DEPTH);
    check("fullpp_ovf", overflow, 0);
    repeat (DEPTH + 1) step(m_a, m_b, 1, 0, 1);

    // Saturation and clear with a non-empty FIFO
    for (int i = 0; i < 17; i++) step(!m_a, m_b, 1, 0, 1);
    for (int i = 0; i < 3; i++) step(!m_a, m_b, 1, 0, 0);
    check("sat_a_tog", a_toggles, CNT_MAX);
    step(m_a, m_b, 1, 1, 0);
    check("clr_a_tog", a_toggles, 0);
    check("clr_count", fifo_count, DEPTH);

    // Asynchronous reset mid-drain
    step(m_a, m_b, 1, 0, 1);
    #2 reset_n = 1'b0;
    #1;
    check("async_evt_valid", evt_valid, 0);
    check("async_count", fifo_count, 0);
    check("async_data", evt_data, 0);
    model_reset();
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    check_state();

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      step(($urandom % 3) == 0 ? !m_a : m_a,
           ($urandom % 3) == 0 ? !m_b : m_b,
           ($urandom % 8) != 0,
           ($urandom % 50) == 0,
           ($urandom % 3) != 0);
    end
    repeat (DEPTH + 1) step(m_a, m_b, 1, 0, 1);
    check("sb_drained", sb_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/edge_event_logger.md
Name: edge_event_logger

Overview:
- Downstream consumer of the swap-register stage: samples its two 1-bit outputs (a, b) on every rising clock edge.
- Detects value changes and time-stamps each changed sample into an event record.
- Buffers records in a small FIFO, drained over a valid/ready handshake by a monitor or trace port.
- Keeps per-signal toggle counts and a sticky overflow flag for debug.

Parameters:
- DEPTH, 4, FIFO entries; power of two, ≥2.
- TS_W, 8, timestamp width; free-running, wraps.
- CNT_W, 8, toggle counter width; saturating.

Ports:
- clock  input  1  single clock; all state updates on posedge.
- reset_n  input  1  asynchronous active-low reset.
- a_in  input  1  upstream signal a, synchronous to clock.
- b_in  input  1  upstream signal b, synchronous to clock.
- enable  input  1  sampling enable.
- clear  input  1  synchronous clear of counters and overflow; FIFO untouched.
- evt_valid  output  1  FIFO head holds a record.
- evt_ready  input  1  consumer accepts head record.
- evt_data  output  TS_W+4  record {ts, a_val, b_val, a_chg, b_chg}; MSB = ts MSB.
- a_toggles  output  CNT_W  count of a changes.
- b_toggles  output  CNT_W  count of b changes.
- fifo_count  output  clog2(DEPTH)+1  occupancy.
- overflow  output  1  sticky: a record was dropped.

Behaviour:
- Reset (async assert, sync release): evt_valid=0, evt_data=0, a_toggles=0, b_toggles=0, fifo_count=0, overflow=0.
  - Internal state resets as well: ts=0, a_last=0, b_last=0, primed=0, FIFO pointers=0.
  - Reset mid-operation discards all queued records.
- Timestamp:
  - ts increments every clock regardless of enable.
  - Wraps 2^TS_W-1 -> 0.
  - A record carries the ts value present before that edge's increment.
- Sampling (enable=1 at posedge):
  - a_last<=a_in and b_last<=b_in.
  - If primed=0: set primed=1; no record, no count. The first enabled sample after reset only primes.
  - If primed=1: a_chg=a_in^a_last and b_chg=b_in^b_last.
  - If a_chg|b_chg, push record {ts, a_in, b_in, a_chg, b_chg}.
- enable=0: no sampling, no push, last values held. primed is not cleared.
- Latency: a change sampled at posedge k appears at the FIFO head, with evt_valid=1, after edge k when the FIFO was empty. No combinational path from inputs to evt_*.
- Counters:
  - a_toggles += a_chg and b_toggles += b_chg on each push.
  - Saturate at 2^CNT_W-1, no wrap.
  - clear=1 zeroes both counters and overflow; clear takes priority over a same-cycle increment.
- FIFO:
  - Pop when evt_valid & evt_ready.
  - evt_data is registered or memory-read and valid whenever evt_valid=1.
  - evt_data holds stable while evt_valid=1 & evt_ready=0.
- Full (fifo_count=DEPTH) with a push request:
  - With a same-cycle pop: push accepted; count unchanged.
  - Without a pop: record dropped, overflow<=1, counters still updated.
- Empty with evt_ready=1: no effect.
- Simultaneous push+pop when not full or empty: count unchanged, order preserved.
- Pointers wrap modulo DEPTH.
- overflow stays 1 until clear or reset.

Decomposition:
- Shared package edge_event_pkg holds:
  - record field offsets and widths (TS_LSB, A_VAL_BIT, B_VAL_BIT, A_CHG_BIT, B_CHG_BIT);
  - the record width function of TS_W.
- One sub-module: sync_fifo_vr (parameterised DEPTH/WIDTH, valid/ready output, count, full/empty).
- Change detection, timestamp and counters live in the top module.

Test Plan:
- Reset/prime: reset_n low 3 cycles, release, a_in=1, b_in=0, enable=1 -> first edge no record; evt_valid=0, toggles 0/0, fifo_count=0.
- Single change: after priming with ts=5 at sample, drive a_in 1->0 -> next cycle evt_valid=1, evt_data={8'd5,0,0,1,0}, a_toggles=1, b_toggles=0.
- Swap pattern: upstream a/b swapping each posedge from a=1, b=0 with evt_ready=1 -> one record per cycle, a_chg=b_chg=1 every record; after 10 records both toggles =10; ts increments by 1 per record.
- Overflow: evt_ready=0, DEPTH=4, 6 change cycles -> fifo_count=4, overflow=1, toggles count all 6. Then evt_ready=1 -> the first 4 records drain in order; evt_data is stable while stalled.
- Full push+pop: FIFO full, evt_ready=1 with a change same cycle -> no drop, overflow stays 0, fifo_count stays 4.
- Saturation/clear/async reset: CNT_W=4, 20 toggles -> a_toggles=15. clear=1 -> 0, overflow=0, FIFO unchanged. reset_n low mid-drain, asynchronous to clock -> evt_valid=0 immediately.
